// File: rtl/timer_pkg.sv
// Shared timer-channel types: clock-division/prescaler encodings, capture FSM
// states and the ICxF filter decode (sample-rate select and confirm count N).
package timer_pkg;

  typedef enum logic [1:0] {CKD_DIV1, CKD_DIV2, CKD_DIV4, CKD_DIV4B} ckd_e;
  typedef enum logic [1:0] {PSC_1, PSC_2, PSC_4, PSC_8} icpsc_e;
  typedef enum logic {IC_DISABLED, IC_RUN} ic_state_e;

  // div_sel: 0 = sample every kernel clock, k = sample every 2^k DTS ticks
  typedef struct packed {
    logic [2:0] div_sel;
    logic [3:0] n;
  } icf_dec_t;

  function automatic icf_dec_t icf_decode(input logic [3:0] icf);
    icf_dec_t d;
    case (icf)
      4'd0:    d = {3'd0, 4'd1};
      4'd1:    d = {3'd0, 4'd2};
      4'd2:    d = {3'd0, 4'd4};
      4'd3:    d = {3'd0, 4'd8};
      4'd4:    d = {3'd1, 4'd6};
      4'd5:    d = {3'd1, 4'd8};
      4'd6:    d = {3'd2, 4'd6};
      4'd7:    d = {3'd2, 4'd8};
      4'd8:    d = {3'd3, 4'd6};
      4'd9:    d = {3'd3, 4'd8};
      4'd10:   d = {3'd4, 4'd5};
      4'd11:   d = {3'd4, 4'd6};
      4'd12:   d = {3'd4, 4'd8};
      4'd13:   d = {3'd5, 4'd5};
      4'd14:   d = {3'd5, 4'd6};
      default: d = {3'd5, 4'd8};
    endcase
    return d;
  endfunction

endpackage

// File: rtl/input_capture_ctrl_if.sv
// Configuration, timer input and capture outputs of one input-capture channel.
interface input_capture_ctrl_if;
  logic       en_i;
  logic       ti_i;
  logic [1:0] ckd_i;
  logic [3:0] icf_i;
  logic       ccp_i;
  logic       ccnp_i;
  logic [1:0] icpsc_i;
  logic       cfg_upd_i;
  logic       tif_o;
  logic       ic_o;

  modport master (output en_i, ti_i, ckd_i, icf_i, ccp_i, ccnp_i, icpsc_i, cfg_upd_i,
                  input  tif_o, ic_o);
  modport slave  (input  en_i, ti_i, ckd_i, icf_i, ccp_i, ccnp_i, icpsc_i, cfg_upd_i,
                  output tif_o, ic_o);
endinterface

// File: rtl/sample_strobe_gen.sv
// DTS prescaler (1/2/4 clocks) followed by a 2^div_sel sample divider; emits
// the filter sample strobe, or a strobe every cycle when div_sel is 0.
module sample_strobe_gen
  import timer_pkg::*;
(
  input  logic       clk_i,
  input  logic       aresetn_i,
  input  logic       clr,
  input  ckd_e       ckd,
  input  logic [2:0] div_sel,
  output logic       sample_stb
);

  logic [1:0] dts_q, dts_max;
  logic [4:0] div_q, div_max;
  logic [5:0] span;
  logic       dts_tick;

  always_comb begin
    dts_max = 2'd3;
    case (ckd)
      CKD_DIV1: dts_max = 2'd0;
      CKD_DIV2: dts_max = 2'd1;
      default:  dts_max = 2'd3;
    endcase
    span    = 6'd1 << div_sel;
    div_max = 5'(span - 6'd1);
  end

  assign dts_tick   = (dts_q == dts_max);
  assign sample_stb = !clr && ((div_sel == 3'd0) || (dts_tick && (div_q == div_max)));

  always_ff @(posedge clk_i or negedge aresetn_i) begin
    if (!aresetn_i) begin
      dts_q <= '0;
      div_q <= '0;
    end else if (clr) begin
      dts_q <= '0;
      div_q <= '0;
    end else if (dts_tick) begin
      dts_q <= '0;
      div_q <= (div_q == div_max) ? 5'd0 : div_q + 5'd1;
    end else begin
      dts_q <= dts_q + 2'd1;
    end
  end

endmodule

// File: rtl/input_capture_ctrl.sv
// Input-capture front end: config shadows, digital confirm filter, polarity
// edge detect and capture prescaler producing a single-cycle capture event.
module input_capture_ctrl
  import timer_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 aresetn_i,
  input_capture_ctrl_if.slave  bus
);

  ic_state_e  state_q, state_d;
  ckd_e       ckd_q;
  icpsc_e     icpsc_q;
  logic [3:0] icf_q;
  logic       ccp_q, ccnp_q;
  logic       run, load, sample_stb;
  icf_dec_t   dec;
  logic [2:0] cnt_q, psc_q, psc_max;
  logic       tif_q, tif_d_q, ic_q;
  logic       rise, fall, edge_vld;

  always_ff @(posedge clk_i or negedge aresetn_i) begin
    if (!aresetn_i) state_q <= IC_DISABLED;
    else            state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    run     = 1'b0;
    case (state_q)
      IC_DISABLED: if (bus.en_i) state_d = IC_RUN;
      IC_RUN: begin
        run = 1'b1;
        if (!bus.en_i) state_d = IC_DISABLED;
      end
      default: state_d = IC_DISABLED;
    endcase
  end

  assign load = bus.cfg_upd_i || !bus.en_i;

  always_ff @(posedge clk_i or negedge aresetn_i) begin
    if (!aresetn_i) begin
      ckd_q   <= CKD_DIV1;
      icf_q   <= '0;
      ccp_q   <= 1'b0;
      ccnp_q  <= 1'b0;
      icpsc_q <= PSC_1;
    end else if (load) begin
      ckd_q   <= ckd_e'(bus.ckd_i);
      icf_q   <= bus.icf_i;
      ccp_q   <= bus.ccp_i;
      ccnp_q  <= bus.ccnp_i;
      icpsc_q <= icpsc_e'(bus.icpsc_i);
    end
  end

  assign dec = icf_decode(icf_q);

  sample_strobe_gen u_stb (
    .clk_i      (clk_i),
    .aresetn_i  (aresetn_i),
    .clr        (load || !run),
    .ckd        (ckd_q),
    .div_sel    (dec.div_sel),
    .sample_stb (sample_stb)
  );

  // While disabled both level copies follow ti_i so enabling never fakes an edge.
  always_ff @(posedge clk_i or negedge aresetn_i) begin
    if (!aresetn_i) begin
      tif_q   <= 1'b0;
      tif_d_q <= 1'b0;
      cnt_q   <= '0;
    end else if (!run) begin
      tif_q   <= bus.ti_i;
      tif_d_q <= bus.ti_i;
      cnt_q   <= '0;
    end else begin
      tif_d_q <= tif_q;
      if (load) begin
        cnt_q <= '0;
      end else if (sample_stb) begin
        if (bus.ti_i == tif_q) begin
          cnt_q <= '0;
        end else if (({1'b0, cnt_q} + 4'd1) == dec.n) begin
          tif_q <= bus.ti_i;
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_q + 3'd1;
        end
      end
    end
  end

  assign rise     = tif_q && !tif_d_q;
  assign fall     = !tif_q && tif_d_q;
  assign edge_vld = ccp_q ? (fall || (ccnp_q && rise)) : rise;
  assign psc_max  = 3'((4'd1 << icpsc_q) - 4'd1);

  always_ff @(posedge clk_i or negedge aresetn_i) begin
    if (!aresetn_i) begin
      psc_q <= '0;
      ic_q  <= 1'b0;
    end else if (!run || load) begin
      psc_q <= '0;
      ic_q  <= 1'b0;
    end else begin
      ic_q <= 1'b0;
      if (edge_vld) begin
        if (psc_q == psc_max) begin
          psc_q <= '0;
          ic_q  <= !ic_q;
        end else begin
          psc_q <= psc_q + 3'd1;
        end
      end
    end
  end

  assign bus.tif_o = tif_q;
  assign bus.ic_o  = ic_q;

endmodule

// File: tb/tb_input_capture_ctrl.sv
// Scoreboard bench for input_capture_ctrl: expected tif/ic events (cycle*4+kind)
// are queued with the stimulus and compared with events seen by a monitor.
module tb_input_capture_ctrl;

  logic clk_i = 1'b0;
  logic aresetn_i = 1'b0;
  always #5 clk_i = ~clk_i;

  input_capture_ctrl_if bus();

  input_capture_ctrl dut (
    .clk_i     (clk_i),
    .aresetn_i (aresetn_i),
    .bus       (bus)
  );

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   exp_q[$];
  int   obs_q[$];
  logic last_tif = 1'b0;

  always @(posedge clk_i) cyc <= cyc + 1;

  // event kinds: 0 tif fall, 1 tif rise, 2 capture pulse
  always @(negedge clk_i) begin
    if (bus.tif_o !== last_tif) obs_q.push_back(cyc * 4 + (bus.tif_o ? 1 : 0));
    if (bus.ic_o === 1'b1) obs_q.push_back(cyc * 4 + 2);
    last_tif <= bus.tif_o;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic setup(input logic [3:0] icf, input logic [1:0] ckd, input logic ccp,
                       input logic ccnp, input logic [1:0] psc);
    bus.en_i = 1'b0; bus.ti_i = 1'b0; bus.cfg_upd_i = 1'b0;
    bus.icf_i = icf; bus.ckd_i = ckd; bus.ccp_i = ccp; bus.ccnp_i = ccnp; bus.icpsc_i = psc;
    tick(3);
    bus.en_i = 1'b1;
    tick(2);
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic test_reset();
    bus.en_i = 1'b0; bus.ti_i = 1'b0; bus.cfg_upd_i = 1'b0;
    bus.icf_i = '0; bus.ckd_i = '0; bus.ccp_i = 1'b0; bus.ccnp_i = 1'b0; bus.icpsc_i = '0;
    aresetn_i = 1'b0;
    tick(2);
    checks++; if (bus.tif_o !== 1'b0) begin errors++; $display("FAIL reset_tif got %b want 0", bus.tif_o); end
    checks++; if (bus.ic_o !== 1'b0) begin errors++; $display("FAIL reset_ic got %b want 0", bus.ic_o); end
    aresetn_i = 1'b1;
    bus.ti_i = 1'b1;
    tick(1);
    checks++; if (bus.tif_o !== 1'b1) begin errors++; $display("FAIL disabled_track got %b want 1", bus.tif_o); end
    bus.ti_i = 1'b0;
    tick(2);
  endtask

  task automatic test_passthrough();
    int t0, e, o;
    setup(4'd0, 2'd0, 1'b0, 1'b0, 2'd0);
    t0 = cyc; bus.ti_i = 1'b1;
    exp_q.push_back((t0 + 1) * 4 + 1); exp_q.push_back((t0 + 2) * 4 + 2);
    tick(4);
    t0 = cyc; bus.ti_i = 1'b0;
    exp_q.push_back((t0 + 1) * 4 + 0);
    tick(4);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++; $display("FAIL passthrough_count got %0d want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = (obs_q.size() > 0) ? obs_q.pop_front() : -1;
      checks++;
      if (o !== e) begin errors++; $display("FAIL passthrough_event got cyc %0d kind %0d want cyc %0d kind %0d", o / 4, o % 4, e / 4, e % 4); end
    end
  endtask

  task automatic test_glitch_reject();
    int t0, e, o;
    setup(4'd2, 2'd0, 1'b0, 1'b0, 2'd0);
    bus.ti_i = 1'b1; tick(3);
    bus.ti_i = 1'b0; tick(4);
    t0 = cyc; bus.ti_i = 1'b1;
    exp_q.push_back((t0 + 4) * 4 + 1); exp_q.push_back((t0 + 5) * 4 + 2);
    tick(4);
    bus.ti_i = 1'b0;
    exp_q.push_back((t0 + 8) * 4 + 0);
    tick(6);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++; $display("FAIL glitch_count got %0d want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = (obs_q.size() > 0) ? obs_q.pop_front() : -1;
      checks++;
      if (o !== e) begin errors++; $display("FAIL glitch_event got cyc %0d kind %0d want cyc %0d kind %0d", o / 4, o % 4, e / 4, e % 4); end
    end
  endtask

  task automatic test_divided();
    int t0, r, c;
    setup(4'd4, 2'd1, 1'b0, 1'b0, 2'd0);
    t0 = cyc; bus.ti_i = 1'b1;
    tick(40);
    checks++;
    if (obs_q.size() != 2) begin
      errors++; $display("FAIL divided_count got %0d want 2", obs_q.size());
    end else begin
      r = obs_q.pop_front(); c = obs_q.pop_front();
      checks++;
      if ((r % 4) != 1 || (r / 4 - t0) < 20 || (r / 4 - t0) > 28) begin
        errors++; $display("FAIL divided_latency got %0d kind %0d want 20..28 kind 1", r / 4 - t0, r % 4);
      end
      checks++;
      if (c !== (r / 4 + 1) * 4 + 2) begin
        errors++; $display("FAIL divided_ic got cyc %0d kind %0d want cyc %0d kind 2", c / 4, c % 4, r / 4 + 1);
      end
    end
  endtask

  task automatic test_back_to_back_psc();
    int t0, e, o;
    logic v;
    setup(4'd0, 2'd0, 1'b1, 1'b1, 2'd2);
    v = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      v = ~v; t0 = cyc; bus.ti_i = v;
      exp_q.push_back((t0 + 1) * 4 + (v ? 1 : 0));
      if (k == 4 || k == 8) exp_q.push_back((t0 + 2) * 4 + 2);
      tick(3);
    end
    tick(3);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++; $display("FAIL psc_count got %0d want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = (obs_q.size() > 0) ? obs_q.pop_front() : -1;
      checks++;
      if (o !== e) begin errors++; $display("FAIL psc_event got cyc %0d kind %0d want cyc %0d kind %0d", o / 4, o % 4, e / 4, e % 4); end
    end
  endtask

  task automatic test_falling_only();
    int t0, e, o;
    setup(4'd0, 2'd0, 1'b1, 1'b0, 2'd0);
    t0 = cyc; bus.ti_i = 1'b1;
    exp_q.push_back((t0 + 1) * 4 + 1);
    tick(3);
    t0 = cyc; bus.ti_i = 1'b0;
    exp_q.push_back((t0 + 1) * 4 + 0); exp_q.push_back((t0 + 2) * 4 + 2);
    tick(4);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++; $display("FAIL falling_count got %0d want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = (obs_q.size() > 0) ? obs_q.pop_front() : -1;
      checks++;
      if (o !== e) begin errors++; $display("FAIL falling_event got cyc %0d kind %0d want cyc %0d kind %0d", o / 4, o % 4, e / 4, e % 4); end
    end
  endtask

  task automatic test_cfg_upd();
    int t0, e, o;
    setup(4'd3, 2'd0, 1'b0, 1'b0, 2'd0);
    t0 = cyc; bus.ti_i = 1'b1;
    tick(3);
    bus.cfg_upd_i = 1'b1;
    tick(1);
    bus.cfg_upd_i = 1'b0;
    exp_q.push_back((t0 + 12) * 4 + 1); exp_q.push_back((t0 + 13) * 4 + 2);
    tick(14);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++; $display("FAIL cfg_upd_count got %0d want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = (obs_q.size() > 0) ? obs_q.pop_front() : -1;
      checks++;
      if (o !== e) begin errors++; $display("FAIL cfg_upd_event got cyc %0d kind %0d want cyc %0d kind %0d", o / 4, o % 4, e / 4, e % 4); end
    end
  endtask

  task automatic test_reset_mid();
    setup(4'd3, 2'd0, 1'b0, 1'b0, 2'd0);
    bus.ti_i = 1'b1;
    tick(3);
    bus.en_i = 1'b0;
    tick(2);
    checks++; if (bus.tif_o !== 1'b1) begin errors++; $display("FAIL disable_track got %b want 1", bus.tif_o); end
    #2 aresetn_i = 1'b0;
    #1;
    checks++; if (bus.tif_o !== 1'b0) begin errors++; $display("FAIL async_reset_tif got %b want 0", bus.tif_o); end
    checks++; if (bus.ic_o !== 1'b0) begin errors++; $display("FAIL async_reset_ic got %b want 0", bus.ic_o); end
    tick(2);
    checks++; if (bus.tif_o !== 1'b0) begin errors++; $display("FAIL held_reset_tif got %b want 0", bus.tif_o); end
    aresetn_i = 1'b1;
    bus.ti_i = 1'b0;
    tick(2);
    checks++; if (bus.tif_o !== 1'b0) begin errors++; $display("FAIL post_reset_tif got %b want 0", bus.tif_o); end
  endtask

  initial begin
    test_reset();
    test_passthrough();
    test_glitch_reject();
    test_divided();
    test_back_to_back_psc();
    test_falling_only();
    test_cfg_upd();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/input_capture_ctrl.md
# input_capture_ctrl

Input-capture front-end controller for one general-purpose timer channel. It decodes the 4-bit input-filter field (ICxF) and clock-division field (CKD) into a sampling rate and a confirm count N, and sequences the digital filter on sample strobes. It also edge-detects the filtered level by polarity and applies the capture prescaler (ICxPSC). The single-cycle capture event drives the channel's capture/compare register and interrupt logic.

## Interface
Parameters:
- none; all widths fixed by the timer register map

Ports:
- clk_i  in  1  timer kernel clock (fCK_INT)
- aresetn_i  in  1  asynchronous active-low reset
- en_i  in  1  channel capture enable (CCxE)
- ti_i  in  1  timer input, already synchronised to clk_i
- ckd_i  in  2  dead-time/sampling clock division: 0 → fDTS=fCK_INT, 1 → /2, 2 → /4, 3 → treated as /4
- icf_i  in  4  input filter code
- ccp_i  in  1  polarity: 0 rising, 1 falling
- ccnp_i  in  1  with ccp_i=1, selects both edges
- icpsc_i  in  2  capture prescaler: every 1/2/4/8 valid edges
- cfg_upd_i  in  1  one-cycle strobe; load configuration shadows
- tif_o  out  1  filtered input level
- ic_o  out  1  capture event, single-cycle pulse

## Operation
- Shadow registers hold ckd, icf, ccp, ccnp, icpsc.
  - They load on cfg_upd_i=1, or on every cycle while en_i=0.
  - A load clears the divider counters, confirm counter and prescaler counter. tif_o is kept.
- Filter decode (sample rate, N):
  - 0: fCK_INT, N=1 (pass-through)
  - 1/2/3: fCK_INT, N=2/4/8
  - 4/5: fDTS/2, N=6/8
  - 6/7: fDTS/4, N=6/8
  - 8/9: fDTS/8, N=6/8
  - 10/11/12: fDTS/16, N=5/6/8
  - 13/14/15: fDTS/32, N=5/6/8
- Strobe generation:
  - A DTS counter produces dts_tick every 1/2/4 clocks.
  - A sample divider counts dts_ticks to D ∈ {2,4,8,16,32} and produces sample_stb.
  - For codes 0-3, sample_stb=1 every cycle.
- Confirm counter (3-bit) runs on each sample_stb:
  - ti_i ≠ tif_o: increment the counter.
  - Counter reaches N: tif_o ← ti_i and the counter clears.
  - ti_i = tif_o: the counter clears, so glitches shorter than N samples are rejected.
- Edge detect uses tif_o and its 1-cycle delayed copy. Valid edge:
  - rising when ccp=0
  - falling when ccp=1, ccnp=0
  - either edge when ccp=1, ccnp=1
  - ccp=0 with ccnp=1 is rising only
- Capture prescaler (3-bit) counts valid edges.
  - ic_o pulses on the edge that makes the count equal PSC-1, where PSC = 1<<icpsc; the counter then wraps to 0.
  - With PSC=1, every valid edge pulses.
- State machine:
  - DISABLED: entered on reset or when en_i=0. Counters held at 0, ic_o=0, tif_o tracks ti_i directly (registered).
  - RUN: entered on en_i=1. Filtering and capture active.
  - RUN → DISABLED on en_i=0 in the next cycle.

## Timing
- Reset values: tif_o=0, ic_o=0, all counters 0, state DISABLED, shadows 0.
- Code 0: tif_o follows ti_i with 1-cycle latency; ic_o one cycle after tif_o changes.
- Codes 1-3: a stable level change on ti_i before edge k appears on tif_o after edge k+N-1; ic_o is high for the following cycle.
- Divided rates: latency is N sample periods, plus up to one sample period of phase uncertainty.
- cfg_upd_i with sample_stb in the same cycle: the update wins and the sample is discarded.
- Prescaler wrap: the counter returns to 0 in the same cycle ic_o is asserted.
- ic_o is never asserted for two consecutive cycles.
- aresetn_i mid-operation: all state clears immediately and asynchronously; outputs go to 0.

## Structure
- Shared package timer_pkg holds:
  - the ckd_e and icpsc_e enums
  - the filter decode function icf_decode(icf) → {div_sel, n}
  - the state typedef ic_state_e
- Sub-module sample_strobe_gen holds the DTS counter and sample divider; its output is sample_stb.
- Confirm counter, edge detect and prescaler stay in the top module.

## Test plan
- icf=0, ccp=0, icpsc=0, single clean rise → tif_o rises 1 cycle later, ic_o pulses once the following cycle.
- icf=2 (N=4), 3-cycle high glitch → no tif_o change and no ic_o. A 4-cycle high pulse → tif_o=1 after edge 4.
- icf=4, ckd=1 (sample every 4 clocks, N=6), steady rise → tif_o rises 24±4 clocks later.
- ccp=1, ccnp=1, icpsc=2 (every 4 edges), 8 input edges → exactly 2 ic_o pulses, on edges 4 and 8.
- cfg_upd_i asserted mid-confirm (counter at 3) → counter clears and tif_o is unchanged; a full N samples are required again.
- en_i dropped, then aresetn_i asserted mid-count → ic_o=0, counters 0, tif_o=0 immediately after reset.
